// File: rtl/audio_pkg.sv
// Shared widths and sample helpers for the audio path (note mux, tone generator, DAC serializer).
package audio_pkg;
  localparam int NOTE_DIV_W  = 22;
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_CNT_W = 9;
  localparam logic [NOTE_DIV_W-1:0] SILENCE_DIV = 22'd1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  function automatic logic [SAMPLE_W-1:0] sq_sample(input logic b, input logic [SAMPLE_W-1:0] vol);
    return b ? vol : (SAMPLE_W'(0) - vol);
  endfunction
endpackage

// File: rtl/audio_serializer.sv
// I2S serializer: derives MCLK/SCK/LRCK from one free-running counter and shifts a latched stereo frame.
module audio_serializer
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin
);
  logic [FRAME_CNT_W-1:0] r_div_cnt;
  frame_t                 r_frame;
  logic                   r_sdin;
  logic [4:0]             w_slot_nxt;
  logic                   w_bit_nxt;

  assign w_slot_nxt = r_div_cnt[8:4] + 5'd1;
  // Bit index is (32 - slot) mod 32: slot 0 picks bit 0 of the frame still held, i.e. the
  // previous frame's right LSB, since the new frame is latched on that same edge.
  assign w_bit_nxt  = r_frame[5'd0 - w_slot_nxt];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_frame   <= '0;
      r_sdin    <= 1'b0;
    end else begin
      r_div_cnt <= r_div_cnt + FRAME_CNT_W'(1);
      if (r_div_cnt == '1)
        r_frame <= '{left: left, right: right};
      if (r_div_cnt[3:0] == 4'hF)
        r_sdin <= w_bit_nxt;
    end
  end

  assign audio_mclk = r_div_cnt[1];
  assign audio_sck  = r_div_cnt[3];
  assign audio_lrck = r_div_cnt[8];
  assign audio_sdin = r_sdin;
endmodule

// File: rtl/speaker_control.sv
// Square-wave tone generator driven by note_div, feeding a mono sample to the I2S DAC serializer.
module speaker_control
  import audio_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] VOLUME = 16'h2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NOTE_DIV_W-1:0] note_div,
  output logic                  audio_mclk,
  output logic                  audio_lrck,
  output logic                  audio_sck,
  output logic                  audio_sdin
);
  logic [NOTE_DIV_W-1:0] r_div_q;
  logic [NOTE_DIV_W-1:0] r_tone_cnt;
  logic                  r_b_clk;
  logic [SAMPLE_W-1:0]   w_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_q    <= '0;
      r_tone_cnt <= '0;
      r_b_clk    <= 1'b0;
    end else begin
      r_div_q <= note_div;
      // A divisor change restarts at phase 0 and beats a coincident terminal count.
      if (note_div != r_div_q || r_div_q <= SILENCE_DIV) begin
        r_tone_cnt <= '0;
        r_b_clk    <= 1'b0;
      end else if (r_tone_cnt == r_div_q - NOTE_DIV_W'(1)) begin
        r_tone_cnt <= '0;
        r_b_clk    <= ~r_b_clk;
      end else begin
        r_tone_cnt <= r_tone_cnt + NOTE_DIV_W'(1);
      end
    end
  end

  assign w_sample = (r_div_q <= SILENCE_DIV) ? '0 : sq_sample(r_b_clk, VOLUME);

  audio_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .left       (w_sample),
    .right      (w_sample),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin)
  );
endmodule

// File: tb/tb_speaker_control.sv
// Directed bench: per-cycle pin checks plus a frame scoreboard fed by an I2S deserializing monitor.
module tb_speaker_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] note_div = 22'd191571;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

  localparam int R2 = 5422;  // cycle index of the second reset release

  int          total = 0;
  int          bad   = 0;
  int          k     = 0;
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;

  speaker_control dut (
    .clk        (clk),
    .rst        (rst),
    .note_div   (note_div),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: rebuilds each 32-bit frame from SDIN at SCK rising edges, aligned to LRCK falling.
  initial begin
    logic        prev_lrck = 1'b0, prev_sck = 1'b0, prev_sdin = 1'b0;
    logic [31:0] cur = '0, pend = '0;
    logic        pend_v = 1'b0;
    int          idx = -1;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        idx    = -1;
        pend_v = 1'b0;
      end else begin
        if (audio_sdin !== prev_sdin)
          chk("sdin_on_sck_fall", {31'b0, prev_sck & ~audio_sck}, 32'd1);
        if (prev_lrck && !audio_lrck) begin
          pend   = cur;
          pend_v = (idx == 32);
          idx    = 0;
          cur    = '0;
        end
        if (!prev_sck && audio_sck && idx >= 0) begin
          if (idx == 0) begin
            if (pend_v) begin
              pend[0] = audio_sdin;
              if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_unexpected k=%0d got=%h exp=none", k, pend);
              end else begin
                chk("frame", pend, exp_q.pop_front());
              end
            end
            idx = 1;
          end else begin
            cur[32-idx] = audio_sdin;
            idx++;
          end
        end
      end
      prev_lrck = audio_lrck;
      prev_sck  = audio_sck;
      prev_sdin = audio_sdin;
    end
  end

  initial begin
    logic eb;
    repeat (3) begin
      step();
      chk("reset_pins", {28'b0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
      chk("reset_tone_cnt", {10'b0, dut.r_tone_cnt}, 32'd0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    exp_q.push_back(32'hE000_E000);
    exp_q.push_back(32'hE000_E000);

    while (k < R2 + 1040) begin
      step();
      k++;
      if (k == 1)   chk("mclk_k1", {31'b0, audio_mclk}, 32'd0);
      if (k == 2)   chk("mclk_k2", {31'b0, audio_mclk}, 32'd1);
      if (k == 255) chk("lrck_k255", {31'b0, audio_lrck}, 32'd0);
      if (k == 256) chk("lrck_k256", {31'b0, audio_lrck}, 32'd1);
      if (k <= 527) chk("sdin_silent_after_reset", {31'b0, audio_sdin}, 32'd0);
      if (k == 528) chk("sdin_first_bit", {31'b0, audio_sdin}, 32'd1);
      if (k >= 1025 && k <= 3072) chk("silence_b_clk", {31'b0, dut.r_b_clk}, 32'd0);
      if (k >= 1536 && k <= 3599) chk("silence_sdin", {31'b0, audio_sdin}, 32'd0);
      if (k == 3073) chk("div4_restart_cnt", {10'b0, dut.r_tone_cnt}, 32'd0);
      if (k >= 3073 && k <= 3100) begin
        eb = (k < 3077) ? 1'b0 : 1'(((k - 3077) / 4 + 1) % 2);
        chk("div4_b_clk", {31'b0, dut.r_b_clk}, {31'b0, eb});
      end
      if (k == 4103) chk("div8_cnt_before_change", {10'b0, dut.r_tone_cnt}, 32'd6);
      if (k == 4104) chk("div5_restart_cnt", {10'b0, dut.r_tone_cnt}, 32'd0);
      if (k >= 4104 && k <= 4130) begin
        eb = 1'(((k - 4104) / 5) % 2);
        chk("div5_b_clk", {31'b0, dut.r_b_clk}, {31'b0, eb});
      end
      if (k == 5421) begin
        chk("midreset_pins", {28'b0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
        chk("midreset_tone", {9'b0, dut.r_b_clk, dut.r_tone_cnt}, 32'd0);
        chk("midreset_queue", exp_q.size(), 32'd0);
      end
      if (k > R2 && k <= R2 + 527) chk("sdin_silent_after_midreset", {31'b0, audio_sdin}, 32'd0);
      if (k == R2 + 2)   chk("mclk_after_midreset", {31'b0, audio_mclk}, 32'd1);
      if (k == R2 + 528) chk("sdin_first_bit_midreset", {31'b0, audio_sdin}, 32'd1);

      case (k)
        1024: begin
          note_div = 22'd1;
          repeat (4) exp_q.push_back(32'h0000_0000);
        end
        3072: begin
          note_div = 22'd4;
          exp_q.push_back(32'h2000_2000);
          exp_q.push_back(32'h2000_2000);
          exp_q.push_back(32'hE000_E000);
        end
        4096: note_div = 22'd8;
        4103: note_div = 22'd5;
        5420: begin
          rst    = 1'b1;
          mon_en = 1'b0;
        end
        R2: begin
          rst    = 1'b0;
          mon_en = 1'b1;
          exp_q.push_back(32'hE000_E000);
        end
        default: ;
      endcase
    end
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
